// File: rtl/quad_decoder_if.sv
// Encoder-side bundle for quad_decoder: raw A/B/Z lines and controls in,
// counter-facing step/direction/index events out.
interface quad_decoder_if;
    logic       enable;
    logic       qa;
    logic       qb;
    logic       qz;
    logic       err_clr;
    logic       counten;
    logic       inc;
    logic       clear;
    logic       err;
    logic [1:0] ab;

    modport master (
        output enable, qa, qb, qz, err_clr,
        input  counten, inc, clear, err, ab
    );

    modport slave (
        input  enable, qa, qb, qz, err_clr,
        output counten, inc, clear, err, ab
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature-encoder front end: synchronises and glitch-filters A/B/Z, then
// turns Gray-code steps into counten/inc pulses and filtered index into clear.
module quad_decoder #(
    parameter int FILTER_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    quad_decoder_if.slave bus
);

    localparam logic [3:0] FC_LAST = 4'(FILTER_LEN - 1);

    // channel order in all vectors below is {a, b, z}
    logic [2:0] meta;
    logic [2:0] sync;
    logic [2:0] filt;
    logic [3:0] fc [0:2];

    logic [1:0] prev_ab;
    logic       prev_z;
    logic       counten_r;
    logic       inc_r;
    logic       clear_r;
    logic       err_r;

    logic [1:0] cur_bin;
    logic [1:0] prev_bin;
    logic [1:0] delta;
    logic       step_fwd;
    logic       step_rev;
    logic       step_bad;

    // A channel only adopts a new level after it has disagreed with the
    // filtered value for FILTER_LEN consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 3'b000;
            sync <= 3'b000;
            filt <= 3'b000;
            for (int i = 0; i < 3; i++) fc[i] <= 4'd0;
        end else begin
            meta <= {bus.qa, bus.qb, bus.qz};
            sync <= meta;
            for (int i = 0; i < 3; i++) begin
                if (sync[i] == filt[i]) begin
                    fc[i] <= 4'd0;
                end else if (fc[i] == FC_LAST) begin
                    filt[i] <= sync[i];
                    fc[i]   <= 4'd0;
                end else begin
                    fc[i] <= fc[i] + 4'd1;
                end
            end
        end
    end

    // Gray-to-binary makes the step direction a simple modulo-4 difference.
    always_comb begin
        cur_bin  = {filt[2], filt[2] ^ filt[1]};
        prev_bin = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
        delta    = cur_bin - prev_bin;
        step_fwd = (delta == 2'd1);
        step_rev = (delta == 2'd3);
        step_bad = (delta == 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ab   <= 2'b00;
            prev_z    <= 1'b0;
            counten_r <= 1'b0;
            inc_r     <= 1'b1;
            clear_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            prev_ab   <= filt[2:1];
            prev_z    <= filt[0];
            counten_r <= bus.enable & (step_fwd | step_rev);
            clear_r   <= bus.enable & filt[0] & ~prev_z & (filt[2:1] == 2'b00);
            if (step_fwd) begin
                inc_r <= 1'b1;
            end else if (step_rev) begin
                inc_r <= 1'b0;
            end
            // a new illegal step outranks a simultaneous clear request
            if (bus.enable && step_bad) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.counten = counten_r;
    assign bus.inc     = inc_r;
    assign bus.clear   = clear_r;
    assign bus.err     = err_r;
    assign bus.ab      = filt[2:1];

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed vector table plus randomized A/B/Z
// traffic checked every cycle against a history-window reference model.
module tb_quad_decoder;

    localparam int L = 4;

    typedef struct {
        logic       qa;
        logic       qb;
        logic       qz;
        logic       en;
        logic       ec;
        int         cycles;
        int         pulses;
        int         clears;
        logic       inc;
        logic       err;
        logic [1:0] ab;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    quad_decoder_if bif ();

    quad_decoder #(.FILTER_LEN(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int row_pulses = 0;
    int row_clears = 0;
    vec_t rows[$];

    // reference model: raw input history and filtered levels, {a, b, z}
    logic [2:0] hist[$];
    logic [2:0] m_filt;
    logic [2:0] m_filt_prev;
    logic       m_counten;
    logic       m_inc;
    logic       m_clear;
    logic       m_err;

    function automatic int gpos(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < L + 2; i++) hist.push_back(3'b000);
        m_filt      = 3'b000;
        m_filt_prev = 3'b000;
        m_counten   = 1'b0;
        m_inc       = 1'b1;
        m_clear     = 1'b0;
        m_err       = 1'b0;
    endtask

    // A level reaches the filtered output once the last L synchronised
    // samples (raw delayed by two flops) all disagree with it.
    task automatic model_step(input logic [2:0] raw, input logic en, input logic ec);
        logic [2:0] nf;
        int d;
        hist.push_back(raw);
        void'(hist.pop_front());
        for (int ch = 0; ch < 3; ch++) begin
            bit all_diff = 1'b1;
            for (int i = 0; i < L; i++) begin
                if (hist[i][ch] == m_filt[ch]) all_diff = 1'b0;
            end
            nf[ch] = all_diff ? ~m_filt[ch] : m_filt[ch];
        end
        d = (gpos(m_filt[2:1]) - gpos(m_filt_prev[2:1]) + 4) % 4;
        m_counten = en && (d == 1 || d == 3);
        if (d == 1) m_inc = 1'b1;
        else if (d == 3) m_inc = 1'b0;
        if (en && d == 2) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
        m_clear = en && m_filt[0] && !m_filt_prev[0] && (m_filt[2:1] == 2'b00);
        m_filt_prev = m_filt;
        m_filt      = nf;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_output();
        check($sformatf("cycle%0d {counten,inc,clear,err,ab}", cycle),
              {2'b00, bif.counten, bif.inc, bif.clear, bif.err, bif.ab},
              {2'b00, m_counten, m_inc, m_clear, m_err, m_filt[2:1]});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step({bif.qa, bif.qb, bif.qz}, bif.enable, bif.err_clr);
        #1;
        cycle++;
        check_output();
        row_pulses += int'(bif.counten);
        row_clears += int'(bif.clear);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bif.qa      = v.qa;
        bif.qb      = v.qb;
        bif.qz      = v.qz;
        bif.enable  = v.en;
        bif.err_clr = v.ec;
    endtask

    task automatic add(input logic qa, input logic qb, input logic qz, input logic en,
                       input logic ec, input int cyc, input int pulses, input int clears,
                       input logic inc, input logic err, input logic [1:0] ab);
        vec_t v;
        v.qa = qa; v.qb = qb; v.qz = qz; v.en = en; v.ec = ec;
        v.cycles = cyc; v.pulses = pulses; v.clears = clears;
        v.inc = inc; v.err = err; v.ab = ab;
        rows.push_back(v);
    endtask

    initial begin
        int hold;
        // qa qb qz en ec cyc pulses clears inc err ab
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0, 2'b11);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0, 2'b10);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 2'b10);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 2'b11);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  3, 0, 0, 1'b0, 1'b0, 2'b11);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b0, 2'b11);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b1, 2'b11);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  5, 0, 0, 1'b0, 1'b1, 2'b11);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1, 0, 0, 1'b0, 1'b0, 2'b11);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  3, 0, 0, 1'b0, 1'b0, 2'b11);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  7, 0, 0, 1'b0, 1'b1, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 0, 0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  8, 0, 1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0, 2'b11);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  8, 0, 0, 1'b1, 1'b0, 2'b11);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b0, 2'b11);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0, 2'b11);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b0, 2'b11);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0, 2'b10);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0, 2'b01);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b0, 2'b01);

        bif.qa = 1'b0; bif.qb = 1'b0; bif.qz = 1'b0;
        bif.enable = 1'b1; bif.err_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();

        // first step must surface exactly at the seventh edge
        bif.qb = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("latency edge%0d", i), {7'd0, bif.counten}, {7'd0, i == 7});
        end
        repeat (3) tick();

        for (int r = 0; r < rows.size(); r++) begin
            apply_stimulus(rows[r]);
            row_pulses = 0;
            row_clears = 0;
            repeat (rows[r].cycles) tick();
            check($sformatf("row%0d pulses", r), 8'(row_pulses), 8'(rows[r].pulses));
            check($sformatf("row%0d clears", r), 8'(row_clears), 8'(rows[r].clears));
            check($sformatf("row%0d {inc,err,ab}", r), {4'd0, bif.inc, bif.err, bif.ab},
                  {4'd0, rows[r].inc, rows[r].err, rows[r].ab});
        end

        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                bif.qa     = 1'($urandom_range(0, 1));
                bif.qb     = 1'($urandom_range(0, 1));
                bif.qz     = 1'($urandom_range(0, 1));
                bif.enable = ($urandom_range(0, 7) != 0);
                hold       = int'($urandom_range(1, 12));
            end
            hold--;
            bif.err_clr = ($urandom_range(0, 15) == 0);
            if (c == 700) begin
                reset = 1'b1;
                #1;
                check("async reset", {2'b00, bif.counten, bif.inc, bif.clear, bif.err, bif.ab},
                      8'b0001_0000);
                repeat (3) tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature-encoder front end that drives the 8-bit up/down counter's control inputs.
- Synchronises and glitch-filters raw A/B/Z encoder lines and decodes Gray-code steps into one-cycle counten pulses, with an inc direction level and a clear pulse on index.
- Flags illegal A/B transitions.
- Outputs connect directly to the counter's counten, inc and clear. The counter's load is tied 0 at integration.

Parameters:
- FILTER_LEN, 4: consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates. Legal range 1..15; the per-channel filter counter is 4 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = emit counten/clear/err events; 0 = track silently
- qa  input  1  encoder channel A, asynchronous
- qb  input  1  encoder channel B, asynchronous
- qz  input  1  encoder index, asynchronous
- err_clr  input  1  synchronous clear of sticky err
- counten  output  1  one-cycle step pulse to counter
- inc  output  1  direction of last step: 1 = up, 0 = down
- clear  output  1  one-cycle index pulse to counter
- err  output  1  sticky illegal-transition flag
- ab  output  2  filtered {A,B}, for debug/status

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - all synchroniser flops, filtered A/B/Z, previous-AB register and filter counters = 0
  - counten = 0, clear = 0, err = 0, ab = 2'b00, inc = 1
  - Reset asserted mid-operation takes effect immediately; there is no event output on release.
- Synchroniser: two flops per channel (qa, qb, qz). The second stage is "sync".
- Filter, per channel, counter fc:
  - sync == filt: fc <= 0.
  - Otherwise, if fc == FILTER_LEN-1: filt <= sync, fc <= 0.
  - Otherwise fc <= fc+1.
  - A pulse shorter than FILTER_LEN cycles at sync never reaches filt.
- Decode compares current filt AB against prev (filt AB from the previous cycle). prev <= filt AB every cycle, regardless of enable.
  - Forward sequence 00->01->11->10->00: counten <= 1, inc <= 1.
  - Reverse sequence 00->10->11->01->00: counten <= 1, inc <= 0.
  - Both bits changed (00<->11, 01<->10): counten <= 0, inc unchanged, err <= 1.
  - No change: counten <= 0, inc holds.
- counten is registered and high for exactly one cycle per legal step.
- Latency: a qa/qb change stable before clock edge 1 produces counten high after edge 3+FILTER_LEN (edge 7 at default), counting the first sampling edge as edge 1.
- Index: clear <= 1 for one cycle on a rising edge of filtered Z, only if the current filtered AB == 00. Z rising with AB != 00 is ignored. Z filter latency matches A/B.
- enable = 0:
  - counten, clear and err setting are suppressed (forced 0 / no set).
  - Synchroniser, filters and prev keep running, so re-enabling produces no spurious step.
  - inc still updates on legal steps.
- err: set on an illegal transition while enable = 1; cleared by err_clr. Set wins if both occur in the same cycle.
- clear and counten may both be 1 in the same cycle (Z edge coinciding with a step into 00). Both are emitted; the downstream counter gives clear priority.
- ab = filtered {A,B}, registered.
- Maximum step rate: one step per FILTER_LEN cycles. Faster input changes are filtered away, or appear as illegal double changes and set err.

Test Plan:
- Reset / initial state: assert reset for 3 cycles, release with qa=qb=qz=0 -> counten=0, clear=0, err=0, inc=1, ab=00 for 20 cycles.
- Forward step: FILTER_LEN=4, enable=1, drive AB 00->01->11->10->00 with each state held 10 cycles -> 4 single-cycle counten pulses with inc=1; the first pulse follows edge 7 after the qb change.
- Reverse steps plus glitch:
  - Drive AB 00->10->11 -> 2 pulses, inc=0.
  - Then a 3-cycle glitch on qa -> no counten, ab stays 11.
- Illegal transition: from AB=00 drive qa and qb high on the same cycle -> no counten, err=1 and held.
  - err_clr pulse -> err=0.
  - err_clr in the same cycle as a new illegal step -> err stays 1.
- Index: with AB=00, pulse qz high for 8 cycles -> one clear pulse. Repeat with AB=11 -> no clear.
- Enable gating: enable=0 while stepping 00->01->11, then enable=1 with no input change -> zero counten pulses, inc=1, ab=11. The next step 11->10 yields exactly one pulse.
